// File: rtl/pipe_rate_change_ctrl.sv
// pipe_rate_change_ctrl: MAC-side PIPE rate-change sequencer (EI force, Rate drive, PclkChangeOk/Ack/PhyStatus handshake, timeout abort)
module pipe_rate_change_ctrl #(
    parameter int LANESNUMBER    = 16,
    parameter int EI_SETTLE      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   req,
    input  logic [3:0]             req_rate,
    input  logic [LANESNUMBER-1:0] active_lanes,
    input  logic                   PclkChangeOk,
    input  logic [LANESNUMBER-1:0] PhyStatus,
    output logic [3:0]             Rate,
    output logic [4:0]             PCLKRate,
    output logic                   PclkChangeAck,
    output logic [LANESNUMBER-1:0] ei_force,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int EW = $clog2(EI_SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, EI_ENTER, RATE_DRIVE, ACK, DONE, ERR} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             tgt_q, prev_q, rate_q, rate_d;
    logic [4:0]             pclk_q, pclk_d;
    logic [LANESNUMBER-1:0] mask_q, seen_q, seen_d, ei_q, ei_d, hit;
    logic [EW-1:0]          ei_cnt_q, ei_cnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   ack_q, done_q, err_q, busy_q, tmo_last, all_seen, in_hs;

    always_comb begin
        hit      = PhyStatus & mask_q;
        all_seen = (seen_q | hit) == mask_q;
        tmo_last = tmo_q == TW'(TIMEOUT_CYCLES - 1);
        in_hs    = state_q == RATE_DRIVE || state_q == ACK;
        state_d  = state_q;
        case (state_q)
            IDLE:       if (req) state_d = (req_rate > 4'd4 || active_lanes == '0) ? ERR :
                                           (req_rate == rate_q) ? DONE : EI_ENTER;
            EI_ENTER:   if (ei_cnt_q == EW'(EI_SETTLE - 1)) state_d = RATE_DRIVE;
            RATE_DRIVE: state_d = PclkChangeOk ? ACK : tmo_last ? ERR : RATE_DRIVE;
            ACK:        state_d = all_seen ? DONE : tmo_last ? ERR : ACK;
            default:    state_d = IDLE;
        endcase
        // Only an aborted handshake restores the saved rate; a reject never moved it
        rate_d   = state_d == RATE_DRIVE ? tgt_q : (in_hs && state_d == ERR) ? prev_q : rate_q;
        pclk_d   = {1'b0, rate_d} + 5'd1;
        ei_d     = (state_d inside {EI_ENTER, RATE_DRIVE, ACK}) ? '1 :
                   (state_d inside {DONE, ERR}) ? ei_q : '0;
        ei_cnt_d = state_q == EI_ENTER ? ei_cnt_q + EW'(1) : '0;
        tmo_d    = in_hs ? (tmo_last ? tmo_q : tmo_q + TW'(1)) : '0;
        seen_d   = state_q == ACK ? seen_q | hit : '0;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            prev_q   <= '0;
            mask_q   <= '0;
            seen_q   <= '0;
            ei_cnt_q <= '0;
            tmo_q    <= '0;
            rate_q   <= '0;
            pclk_q   <= 5'd1;
            ei_q     <= '0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (state_q == IDLE && req) begin
                tgt_q  <= req_rate;
                mask_q <= active_lanes;
                prev_q <= rate_q;
            end
            seen_q   <= seen_d;
            ei_cnt_q <= ei_cnt_d;
            tmo_q    <= tmo_d;
            rate_q   <= rate_d;
            pclk_q   <= pclk_d;
            ei_q     <= ei_d;
            ack_q    <= state_d == ACK;
            done_q   <= state_d == DONE;
            err_q    <= state_d == ERR;
            busy_q   <= state_d != IDLE;
        end
    end

    assign Rate          = rate_q;
    assign PCLKRate      = pclk_q;
    assign PclkChangeAck = ack_q;
    assign ei_force      = ei_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// tb_pipe_rate_change_ctrl: directed and randomized rate-change transactions checked against a cycle-timing model.
module tb_pipe_rate_change_ctrl;
    localparam int L  = 16;
    localparam int ES = 4;
    localparam int T  = 16;
    localparam int R  = ES + 1;

    logic          CLK = 1'b0;
    logic          reset, req, PclkChangeOk;
    logic [3:0]    req_rate, Rate;
    logic [L-1:0]  active_lanes, PhyStatus, ei_force;
    logic [4:0]    PCLKRate;
    logic          PclkChangeAck, busy, done, err;

    int            passed = 0, total = 0, fails = 0;
    logic [3:0]    cur_rate;
    logic          ok_a [64];
    logic [L-1:0]  phy_a [64];

    pipe_rate_change_ctrl #(.LANESNUMBER(L), .EI_SETTLE(ES), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .reset(reset), .req(req), .req_rate(req_rate), .active_lanes(active_lanes),
        .PclkChangeOk(PclkChangeOk), .PhyStatus(PhyStatus), .Rate(Rate), .PCLKRate(PCLKRate),
        .PclkChangeAck(PclkChangeAck), .ei_force(ei_force), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int c = 0; c < 64; c++) begin
            ok_a[c]  = 1'b0;
            phy_a[c] = '0;
        end
    endtask

    // Request issued in cycle 0; ok_a/phy_a give the PHY inputs per cycle.
    // Model: Rate switches at cycle R; the timeout budget T counts cycles from R
    // across both waiting phases; lanes accumulate from the cycle Ack is visible.
    task automatic run_txn(input logic [3:0] t, input logic [L-1:0] lanes);
        int           e, ack_s;
        bit           hs, dn, got;
        logic [L-1:0] acc;
        logic [3:0]   er;
        hs = 0; dn = 0; got = 0; ack_s = 0; e = 1; acc = '0;
        if (t > 4 || lanes == '0) dn = 0;
        else if (t == cur_rate) dn = 1;
        else begin
            hs = 1;
            e  = 0;
            for (int c = R; e == 0 && c < 60; c++) begin
                if (!got) begin
                    if (ok_a[c]) begin got = 1; ack_s = c + 1; end
                    else if (c - R >= T - 1) e = c + 1;
                end else begin
                    acc |= phy_a[c] & lanes;
                    if (acc == lanes) begin dn = 1; e = c + 1; end
                    else if (c - R >= T - 1) e = c + 1;
                end
            end
        end
        req = 1'b1; req_rate = t; active_lanes = lanes;
        PclkChangeOk = ok_a[0]; PhyStatus = phy_a[0];
        for (int k = 1; k <= e + 2; k++) begin
            @(posedge CLK); #1;
            er = (hs && k >= R && (dn || k < e)) ? t : cur_rate;
            chk($sformatf("busy r%0d k%0d", t, k), busy, k <= e);
            chk($sformatf("done r%0d k%0d", t, k), done, k == e && dn);
            chk($sformatf("err r%0d k%0d", t, k), err, k == e && !dn);
            chk($sformatf("ei_force r%0d k%0d", t, k), ei_force, (hs && k <= e) ? {L{1'b1}} : '0);
            chk($sformatf("Rate r%0d k%0d", t, k), Rate, er);
            chk($sformatf("PCLKRate r%0d k%0d", t, k), PCLKRate, {1'b0, er} + 5'd1);
            chk($sformatf("Ack r%0d k%0d", t, k), PclkChangeAck, got && k >= ack_s && k < e);
            req          = (k <= e) ? 1'($urandom) : 1'b0;
            req_rate     = 4'($urandom);
            active_lanes = L'($urandom);
            PclkChangeOk = ok_a[k];
            PhyStatus    = phy_a[k];
        end
        if (hs && dn) cur_rate = t;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; req_rate = '0; active_lanes = '0;
        PclkChangeOk = 1'b0; PhyStatus = '0; cur_rate = 4'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset Rate", Rate, 4'd0);
        chk("reset PCLKRate", PCLKRate, 5'd1);
        chk("reset Ack", PclkChangeAck, 1'b0);
        chk("reset ei_force", ei_force, '0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset err", err, 1'b0);
        reset = 1'b0;
        @(posedge CLK); #1;

        clear_stim();
        run_txn(4'd0, 16'h0001);

        clear_stim();
        ok_a[R + 3] = 1'b1;
        phy_a[3]    = 16'h000F;
        phy_a[11]   = 16'h0003;
        phy_a[13]   = 16'h000C;
        run_txn(4'd2, 16'h000F);

        clear_stim();
        run_txn(4'd7, 16'h000F);
        run_txn(4'd3, 16'h0000);

        clear_stim();
        run_txn(4'd1, 16'h00FF);

        clear_stim();
        ok_a[R + 1]  = 1'b1;
        phy_a[R + 1] = 16'h0003;
        phy_a[9]     = 16'h0001;
        phy_a[10]    = 16'h0020;
        run_txn(4'd4, 16'h0003);

        clear_stim();
        ok_a[R + 1]     = 1'b1;
        phy_a[9]        = 16'h0001;
        phy_a[R + T - 1] = 16'h0002;
        run_txn(4'd4, 16'h0003);

        req = 1'b1; req_rate = 4'd3; active_lanes = 16'h0001;
        @(posedge CLK); #1;
        req = 1'b0;
        repeat (ES) @(posedge CLK);
        #1;
        PclkChangeOk = 1'b1;
        @(posedge CLK); #1;
        PclkChangeOk = 1'b0;
        chk("pre-reset Ack", PclkChangeAck, 1'b1);
        chk("pre-reset Rate", Rate, 4'd3);
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        chk("midreset Rate", Rate, 4'd0);
        chk("midreset PCLKRate", PCLKRate, 5'd1);
        chk("midreset Ack", PclkChangeAck, 1'b0);
        chk("midreset busy", busy, 1'b0);
        chk("midreset ei_force", ei_force, '0);
        chk("midreset done", done, 1'b0);
        chk("midreset err", err, 1'b0);
        @(posedge CLK); #1;
        chk("postreset done", done, 1'b0);
        chk("postreset err", err, 1'b0);
        cur_rate = 4'd0;

        for (int i = 0; i < 30; i++) begin
            int         okc;
            logic [3:0] t;
            logic [L-1:0] ln;
            t   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            ln  = ($urandom_range(0, 7) == 0) ? '0 : L'($urandom & $urandom & $urandom);
            okc = R + $urandom_range(0, 18);
            for (int c = 0; c < 64; c++) begin
                ok_a[c]  = (c < R || c > okc) ? 1'($urandom) : (c == okc);
                phy_a[c] = (c == okc + 1) ? '0 : L'($urandom & $urandom);
            end
            run_txn(t, ln);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
